// File: rtl/dmi_initiator_pkg.sv
// Shared DMI channel types for the DTM-side initiator: request/response
// layouts, DTM op codes and the dmistat encoding.
package dmi_initiator_pkg;

    localparam int unsigned DmiAbits = 7;

    typedef enum logic [1:0] {
        DtmNop      = 2'd0,
        DtmRead     = 2'd1,
        DtmWrite    = 2'd2,
        DtmReserved = 2'd3
    } dtm_op_t;

    typedef enum logic [1:0] {
        DmiSuccess  = 2'd0,
        DmiReserved = 2'd1,
        DmiFailed   = 2'd2,
        DmiBusy     = 2'd3
    } dmi_stat_e;

    typedef struct packed {
        logic [DmiAbits-1:0] addr;
        dtm_op_t             op;
        logic [31:0]         data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StHrst = 2'd3
    } init_state_e;

endpackage

// File: rtl/dmi_initiator.sv
// DTM-side DMI initiator: launches one host command at a time on the DMI
// request channel, captures the response and keeps the sticky dmistat.
//
// state  | meaning
// StIdle | ready to accept a command
// StReq  | request valid, waiting for dmi_req_ready_i
// StWait | request taken, waiting for the response
// StHrst | DMI held in reset after dmihardreset
module dmi_initiator
    import dmi_initiator_pkg::*;
#(
    parameter int unsigned HardResetCycles = 2,
    parameter int unsigned DmiAbits        = dmi_initiator_pkg::DmiAbits
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  update_i,
    input  logic [1:0]            op_i,
    input  logic [DmiAbits-1:0]   addr_i,
    input  logic [31:0]           data_i,
    input  logic                  capture_i,
    output logic [DmiAbits+33:0]  dr_o,
    input  logic                  dmireset_i,
    input  logic                  dmihardreset_i,
    output logic [1:0]            dmistat_o,
    output logic                  busy_o,
    output logic                  dmi_rst_no,
    output logic                  dmi_req_valid_o,
    input  logic                  dmi_req_ready_i,
    output dmi_req_t              dmi_req_o,
    input  logic                  dmi_resp_valid_i,
    output logic                  dmi_resp_ready_o,
    input  dmi_resp_t             dmi_resp_i
);

    localparam int unsigned CntW = (HardResetCycles > 1) ? $clog2(HardResetCycles) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(HardResetCycles - 1);

    init_state_e           state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    dmi_req_t              req_q, req_d;
    logic [DmiAbits-1:0]   addr_q, addr_d;
    logic [31:0]           rdata_q, rdata_d;
    dmi_stat_e             sticky_q, sticky_d;
    logic [DmiAbits+33:0]  dr_q, dr_d;

    logic      in_txn;
    logic      set_busy;
    logic      set_failed;
    dmi_stat_e stat;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            req_q    <= '0;
            addr_q   <= '0;
            rdata_q  <= '0;
            sticky_q <= DmiSuccess;
            dr_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            rdata_q  <= rdata_d;
            sticky_q <= sticky_d;
            dr_q     <= dr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        addr_d     = addr_q;
        rdata_d    = rdata_q;
        sticky_d   = sticky_q;
        dr_d       = dr_q;
        set_busy   = 1'b0;
        set_failed = 1'b0;
        in_txn     = (state_q == StReq) || (state_q == StWait);

        if (sticky_q != DmiSuccess) begin
            stat = sticky_q;
        end else if (in_txn) begin
            stat = DmiBusy;
        end else begin
            stat = DmiSuccess;
        end

        case (state_q)
            StIdle: begin
                if (update_i && (sticky_q == DmiSuccess) && !dmireset_i &&
                    ((op_i == DtmRead) || (op_i == DtmWrite))) begin
                    req_d.addr = addr_i;
                    req_d.op   = dtm_op_t'(op_i);
                    req_d.data = data_i;
                    addr_d     = addr_i;
                    state_d    = StReq;
                end
            end
            StReq: begin
                set_busy = update_i;
                if (dmi_req_ready_i) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                set_busy = update_i;
                if (dmi_resp_valid_i) begin
                    rdata_d    = dmi_resp_i.data;
                    set_failed = (dmi_resp_i.resp != 2'b00);
                    state_d    = StIdle;
                end
            end
            StHrst: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (capture_i && (state_q != StHrst)) begin
            dr_d = {addr_q, rdata_q, stat};
            if (in_txn) begin
                set_busy = 1'b1;
            end
        end

        // A failed response outranks a same-cycle busy collision.
        if (dmireset_i) begin
            sticky_d = DmiSuccess;
        end else if (set_failed) begin
            sticky_d = DmiFailed;
        end else if (set_busy && (sticky_q == DmiSuccess)) begin
            sticky_d = DmiBusy;
        end

        if (dmihardreset_i) begin
            state_d  = StHrst;
            cnt_d    = CntLoad;
            sticky_d = DmiSuccess;
        end
    end

    assign dr_o             = dr_q;
    assign dmistat_o        = sticky_q;
    assign busy_o           = (state_q != StIdle);
    assign dmi_rst_no       = (state_q != StHrst);
    assign dmi_req_valid_o  = (state_q == StReq);
    assign dmi_resp_ready_o = (state_q == StWait);
    assign dmi_req_o        = req_q;

endmodule

// File: tb/tb_dmi_initiator.sv
// Directed and randomized checks of dmi_initiator against a transaction-level
// model of the expected addr/rdata/dmistat.
module tb_dmi_initiator;
    import dmi_initiator_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        update_i = 1'b0;
    logic [1:0]  op_i = '0;
    logic [6:0]  addr_i = '0;
    logic [31:0] data_i = '0;
    logic        capture_i = 1'b0;
    logic [40:0] dr_o;
    logic        dmireset_i = 1'b0;
    logic        dmihardreset_i = 1'b0;
    logic [1:0]  dmistat_o;
    logic        busy_o;
    logic        dmi_rst_no;
    logic        dmi_req_valid_o;
    logic        dmi_req_ready_i = 1'b1;
    dmi_req_t    dmi_req_o;
    logic        dmi_resp_valid_i = 1'b0;
    logic        dmi_resp_ready_o;
    dmi_resp_t   dmi_resp_i = '0;

    int total = 0;
    int bad   = 0;

    logic [6:0]  exp_addr   = '0;
    logic [31:0] exp_rdata  = '0;
    logic [1:0]  exp_sticky = '0;

    dmi_initiator #(.HardResetCycles(2), .DmiAbits(7)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .update_i         (update_i),
        .op_i             (op_i),
        .addr_i           (addr_i),
        .data_i           (data_i),
        .capture_i        (capture_i),
        .dr_o             (dr_o),
        .dmireset_i       (dmireset_i),
        .dmihardreset_i   (dmihardreset_i),
        .dmistat_o        (dmistat_o),
        .busy_o           (busy_o),
        .dmi_rst_no       (dmi_rst_no),
        .dmi_req_valid_o  (dmi_req_valid_o),
        .dmi_req_ready_i  (dmi_req_ready_i),
        .dmi_req_o        (dmi_req_o),
        .dmi_resp_valid_i (dmi_resp_valid_i),
        .dmi_resp_ready_o (dmi_resp_ready_o),
        .dmi_resp_i       (dmi_resp_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_capture();
        capture_i = 1'b1;
        tick();
        capture_i = 1'b0;
    endtask

    task automatic pulse_dmireset();
        dmireset_i = 1'b1;
        tick();
        dmireset_i = 1'b0;
        exp_sticky = 2'd0;
        chk("dmireset_clears", dmistat_o, exp_sticky);
    endtask

    // Full host command: launch, optional stalls, response, then capture.
    task automatic do_txn(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d,
                          input int rdy_dly, input int rsp_dly,
                          input logic [31:0] rd, input logic [1:0] rc);
        bit          issue;
        logic [40:0] exp_req;
        issue   = ((op == 2'd1) || (op == 2'd2)) && (exp_sticky == 2'd0);
        exp_req = {a, op, d};
        op_i = op; addr_i = a; data_i = d;
        dmi_req_ready_i = (rdy_dly == 0);
        update_i = 1'b1;
        tick();
        update_i = 1'b0;
        if (issue) begin
            for (int i = 0; i < rdy_dly; i++) begin
                chk("req_valid_hold", dmi_req_valid_o, 1'b1);
                chk("req_stable", dmi_req_o, exp_req);
                tick();
            end
            dmi_req_ready_i = 1'b1;
            chk("req_valid", dmi_req_valid_o, 1'b1);
            chk("req_payload", dmi_req_o, exp_req);
            tick();
            chk("req_drop", dmi_req_valid_o, 1'b0);
            chk("resp_ready", dmi_resp_ready_o, 1'b1);
            for (int i = 0; i < rsp_dly; i++) tick();
            dmi_resp_i       = '{data: rd, resp: rc};
            dmi_resp_valid_i = 1'b1;
            tick();
            dmi_resp_valid_i = 1'b0;
            exp_addr  = a;
            exp_rdata = rd;
            if (rc != 2'd0) exp_sticky = 2'd2;
            chk("resp_ready_drop", dmi_resp_ready_o, 1'b0);
            chk("idle_after_resp", busy_o, 1'b0);
        end else begin
            chk("no_req", dmi_req_valid_o, 1'b0);
            chk("no_busy", busy_o, 1'b0);
            tick();
            chk("no_req_later", dmi_req_valid_o, 1'b0);
        end
        dmi_req_ready_i = 1'b1;
        chk("dmistat", dmistat_o, exp_sticky);
        pulse_capture();
        chk("dr", dr_o, {exp_addr, exp_rdata, exp_sticky});
    endtask

    initial begin
        tick(); tick();
        rst_i = 1'b0;
        chk("rst_req_valid", dmi_req_valid_o, 1'b0);
        chk("rst_resp_ready", dmi_resp_ready_o, 1'b0);
        chk("rst_dmi_rst_no", dmi_rst_no, 1'b1);
        chk("rst_req", dmi_req_o, 41'd0);
        chk("rst_dr", dr_o, 41'd0);
        chk("rst_stat", dmistat_o, 2'd0);
        chk("rst_busy", busy_o, 1'b0);

        do_txn(2'd2, 7'h10, 32'h8000_0001, 0, 3, 32'h0000_0000, 2'd0);
        do_txn(2'd1, 7'h11, 32'h0, 0, 1, 32'h0000_0C82, 2'd0);
        chk("read_dr_literal", dr_o, {7'h11, 32'h0000_0C82, 2'd0});

        // Request stalled 5 cycles; a colliding update must flag BUSY only.
        op_i = 2'd1; addr_i = 7'h22; data_i = 32'h0;
        dmi_req_ready_i = 1'b0;
        update_i = 1'b1;
        tick();
        update_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", dmi_req_valid_o, 1'b1);
            chk("stall_req", dmi_req_o, {7'h22, 2'd1, 32'h0});
            if (i == 1) begin
                op_i = 2'd2; addr_i = 7'h33; data_i = 32'h5;
                update_i = 1'b1;
            end
            tick();
            update_i = 1'b0;
        end
        chk("stall_busy_stat", dmistat_o, 2'd3);
        exp_sticky = 2'd3;
        pulse_dmireset();
        chk("stall_still_valid", dmi_req_valid_o, 1'b1);
        chk("stall_req_kept", dmi_req_o, {7'h22, 2'd1, 32'h0});
        dmi_req_ready_i = 1'b1;
        tick();
        dmi_resp_i = '{data: 32'h0000_ABCD, resp: 2'd0};
        dmi_resp_valid_i = 1'b1;
        tick();
        dmi_resp_valid_i = 1'b0;
        exp_addr = 7'h22; exp_rdata = 32'h0000_ABCD;
        pulse_capture();
        chk("stall_dr", dr_o, {7'h22, 32'h0000_ABCD, 2'd0});

        // Failed response -> sticky FAILED blocks the next command.
        do_txn(2'd2, 7'h05, 32'h1, 1, 0, 32'h0000_DEAD, 2'd2);
        chk("failed_stat", dmistat_o, 2'd2);
        do_txn(2'd1, 7'h06, 32'h0, 0, 0, 32'h1111_1111, 2'd0);
        pulse_dmireset();

        do_txn(2'd0, 7'h40, 32'h9, 0, 0, 32'h0, 2'd0);
        do_txn(2'd3, 7'h41, 32'h9, 0, 0, 32'h0, 2'd0);
        chk("nop_stat", dmistat_o, 2'd0);

        // Hard reset while waiting for a response.
        op_i = 2'd1; addr_i = 7'h44; data_i = 32'h0;
        update_i = 1'b1;
        tick();
        update_i = 1'b0;
        tick();
        chk("hr_in_wait", dmi_resp_ready_o, 1'b1);
        exp_addr = 7'h44;
        pulse_capture();
        chk("hr_capture_busy", dr_o, {7'h44, exp_rdata, 2'd3});
        chk("hr_sticky_busy", dmistat_o, 2'd3);
        dmihardreset_i = 1'b1;
        tick();
        dmihardreset_i = 1'b0;
        dmi_resp_i = '{data: 32'h0000_0BAD, resp: 2'd2};
        dmi_resp_valid_i = 1'b1;
        op_i = 2'd2; addr_i = 7'h55;
        update_i = 1'b1;
        capture_i = 1'b1;
        chk("hr1_rst_no", dmi_rst_no, 1'b0);
        chk("hr1_resp_ready", dmi_resp_ready_o, 1'b0);
        chk("hr1_busy", busy_o, 1'b1);
        chk("hr1_valid", dmi_req_valid_o, 1'b0);
        chk("hr1_stat", dmistat_o, 2'd0);
        tick();
        update_i = 1'b0;
        capture_i = 1'b0;
        chk("hr2_rst_no", dmi_rst_no, 1'b0);
        chk("hr2_busy", busy_o, 1'b1);
        chk("hr2_stat", dmistat_o, 2'd0);
        tick();
        dmi_resp_valid_i = 1'b0;
        chk("hr_end_rst_no", dmi_rst_no, 1'b1);
        chk("hr_end_busy", busy_o, 1'b0);
        chk("hr_end_valid", dmi_req_valid_o, 1'b0);
        chk("hr_end_stat", dmistat_o, 2'd0);
        chk("hr_dr_held", dr_o, {7'h44, exp_rdata, 2'd3});
        exp_sticky = 2'd0;
        pulse_capture();
        chk("hr_dr_after", dr_o, {7'h44, exp_rdata, 2'd0});

        // Asynchronous reset in the middle of a request.
        op_i = 2'd2; addr_i = 7'h60; data_i = 32'h77;
        dmi_req_ready_i = 1'b0;
        update_i = 1'b1;
        tick();
        update_i = 1'b0;
        chk("arst_pre_valid", dmi_req_valid_o, 1'b1);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_valid", dmi_req_valid_o, 1'b0);
        chk("arst_busy", busy_o, 1'b0);
        chk("arst_dr", dr_o, 41'd0);
        chk("arst_req", dmi_req_o, 41'd0);
        tick();
        rst_i = 1'b0;
        dmi_req_ready_i = 1'b1;
        exp_addr = '0; exp_rdata = '0; exp_sticky = '0;

        for (int n = 0; n < 30; n++) begin
            logic [1:0] rc;
            rc = ($urandom_range(0, 5) == 0) ? 2'd2 : 2'd0;
            do_txn(2'($urandom_range(0, 3)), 7'($urandom), $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom, rc);
            if ((exp_sticky != 2'd0) && ($urandom_range(0, 1) == 1)) pulse_dmireset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
